// File: rtl/led_scanner_pwm.sv
// led_scanner_pwm: scanning LED bar with PWM brightness and button-driven step rate.
// Ports: clk; rst (async, active-low); rate_ctrl, brightness_ctrl (raw buttons);
//        mode[1:0] (0 bounce, 1 wrap, 2 fill, 3 hold); leds; position; step_tick.
// Build option: define LED_TRAIL_EN to light the previous head at half duty.
module led_scanner_pwm #(
    parameter int OUT_WIDTH = 8,
    parameter int PWM_BITS  = 3,
    parameter int BASE_DIV  = 4,
    parameter int POS_W     = $clog2(OUT_WIDTH)
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 rate_ctrl,
    input  logic                 brightness_ctrl,
    input  logic [1:0]           mode,
    output logic [OUT_WIDTH-1:0] leds,
    output logic [POS_W-1:0]     position,
    output logic                 step_tick
);
    localparam logic [1:0] M_BOUNCE = 2'd0;
    localparam logic [1:0] M_WRAP   = 2'd1;
    localparam logic [1:0] M_FILL   = 2'd2;
    localparam logic [1:0] M_HOLD   = 2'd3;

    // Slowest rate is BASE_DIV<<3 clocks per step.
    localparam int PRE_W = $clog2(BASE_DIV * 8);

    localparam logic [POS_W-1:0] LAST = POS_W'(OUT_WIDTH - 1);
    localparam logic [POS_W-1:0] NEAR = POS_W'(OUT_WIDTH - 2);

    // [0],[1] synchroniser, [2] edge-detect delay
    logic [2:0]          rate_sh;
    logic [2:0]          bri_sh;
    logic                rate_press;
    logic                bri_press;

    logic [1:0]          rate_sel;
    logic [PWM_BITS-1:0] level;
    logic [PRE_W-1:0]    presc;
    logic [PRE_W-1:0]    limit;
    logic                term;

    logic [POS_W-1:0]    pos;
    logic                dir_up;
    logic                clear_flag;
    logic [1:0]          cur_mode;

    logic [PWM_BITS-1:0] pwm_cnt;
    logic                head_on;
    logic [OUT_WIDTH-1:0] pattern;

    assign rate_press = rate_sh[1] & ~rate_sh[2];
    assign bri_press  = bri_sh[1] & ~bri_sh[2];

    assign limit = PRE_W'((BASE_DIV << rate_sel) - 1);
    assign term  = (presc == limit);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            rate_sh   <= '0;
            bri_sh    <= '0;
            rate_sel  <= '0;
            level     <= '1;
            presc     <= '0;
            step_tick <= 1'b0;
            pwm_cnt   <= '0;
        end else begin
            rate_sh   <= {rate_sh[1:0], rate_ctrl};
            bri_sh    <= {bri_sh[1:0], brightness_ctrl};
            step_tick <= term;
            pwm_cnt   <= pwm_cnt + PWM_BITS'(1);
            // A press restarts the count so the new rate starts clean.
            if (rate_press || term)
                presc <= '0;
            else
                presc <= presc + PRE_W'(1);
            if (rate_press)
                rate_sel <= rate_sel + 2'd1;
            if (bri_press)
                level <= level - PWM_BITS'(1);
        end
    end

    // Position advances one clock after the registered tick.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            pos        <= '0;
            dir_up     <= 1'b1;
            clear_flag <= 1'b0;
            cur_mode   <= M_BOUNCE;
        end else if (step_tick) begin
            cur_mode <= mode;
            unique case (mode)
                M_BOUNCE: begin
                    clear_flag <= 1'b0;
                    if (dir_up) begin
                        if (pos == LAST) begin
                            dir_up <= 1'b0;
                            pos    <= NEAR;
                        end else begin
                            pos <= pos + POS_W'(1);
                        end
                    end else begin
                        if (pos == '0) begin
                            dir_up <= 1'b1;
                            pos    <= POS_W'(1);
                        end else begin
                            pos <= pos - POS_W'(1);
                        end
                    end
                end
                M_WRAP: begin
                    clear_flag <= 1'b0;
                    dir_up     <= 1'b1;
                    pos        <= (pos == LAST) ? '0 : pos + POS_W'(1);
                end
                M_FILL: begin
                    if (clear_flag) begin
                        pos        <= '0;
                        clear_flag <= 1'b0;
                    end else if (pos == LAST) begin
                        clear_flag <= 1'b1;
                    end else begin
                        pos <= pos + POS_W'(1);
                    end
                end
                M_HOLD: begin
                    clear_flag <= 1'b0;
                end
            endcase
        end
    end

    assign head_on = (pwm_cnt < level);

`ifdef LED_TRAIL_EN
    logic [POS_W-1:0] prev;
    logic             trail_on;

    assign trail_on = (pwm_cnt < (level >> 1));

    always_ff @(posedge clk or negedge rst) begin
        if (!rst)
            prev <= '0;
        else if (step_tick && mode != M_HOLD)
            prev <= pos;
    end
`endif

    always_comb begin
        pattern = '0;
        if (cur_mode == M_FILL) begin
            if (!clear_flag) begin
                for (int i = 0; i < OUT_WIDTH; i++)
                    if (i <= int'(pos))
                        pattern[i] = head_on;
            end
        end else begin
`ifdef LED_TRAIL_EN
            if (cur_mode != M_HOLD && prev != pos)
                pattern[prev] = trail_on;
`endif
            pattern[pos] = head_on;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst)
            leds <= '0;
        else
            leds <= pattern;
    end

    assign position = pos;

endmodule

// File: tb/tb_led_scanner_pwm.sv
// tb_led_scanner_pwm: self-checking bench for led_scanner_pwm.
// OUT_WIDTH=8, PWM_BITS=3, BASE_DIV=4; expectations queued then popped on DUT output.
module tb_led_scanner_pwm;
    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       rate_ctrl = 1'b0;
    logic       brightness_ctrl = 1'b0;
    logic [1:0] mode = 2'd0;
    logic [7:0] leds;
    logic [2:0] position;
    logic       step_tick;

    int errors = 0;
    int checks = 0;
    int exp_q[$];

    led_scanner_pwm #(
        .OUT_WIDTH(8),
        .PWM_BITS(3),
        .BASE_DIV(4)
    ) dut (
        .clk(clk),
        .rst(rst),
        .rate_ctrl(rate_ctrl),
        .brightness_ctrl(brightness_ctrl),
        .mode(mode),
        .leds(leds),
        .position(position),
        .step_tick(step_tick)
    );

    always #5 clk = ~clk;

    initial begin
        #400000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    task automatic wait_tick();
        int n;
        n = 0;
        @(negedge clk);
        while (!step_tick && n < 200) begin
            @(negedge clk);
            n++;
        end
        if (!step_tick) begin
            checks++;
            errors++;
            $display("FAIL tick_timeout got=no tick exp=tick within 200 clocks");
        end
    endtask

    task automatic count_period(output int n);
        wait_tick();
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (!step_tick && n < 200);
    endtask

    task automatic do_reset();
        @(negedge clk);
        mode = 2'd0;
        rate_ctrl = 1'b0;
        brightness_ctrl = 1'b0;
        rst = 1'b0;
        #2;
        rst = 1'b1;
    endtask

    task automatic press(input bit r, input bit b);
        @(negedge clk);
        rate_ctrl = r;
        brightness_ctrl = b;
        repeat (2) @(negedge clk);
        rate_ctrl = 1'b0;
        brightness_ctrl = 1'b0;
        repeat (2) @(negedge clk);
    endtask

    task automatic test_reset();
        int n;
        #2 rst = 1'b0;
        #1;
        checks++;
        if (leds !== 8'h00) begin
            errors++;
            $display("FAIL reset_leds got=%0h exp=0", leds);
        end
        checks++;
        if (position !== 3'd0) begin
            errors++;
            $display("FAIL reset_pos got=%0d exp=0", position);
        end
        checks++;
        if (step_tick !== 1'b0) begin
            errors++;
            $display("FAIL reset_tick got=%0b exp=0", step_tick);
        end
        @(negedge clk);
        rst = 1'b1;
        n = 0;
        do begin
            @(posedge clk);
            #1;
            n++;
        end while (!step_tick && n < 50);
        checks++;
        if (n !== 4) begin
            errors++;
            $display("FAIL first_tick_edge got=%0d exp=4", n);
        end
        // tick seen above is reported again by the first wait_tick
        repeat (2) wait_tick();
        @(negedge clk);
        checks++;
        if (position !== 3'd2) begin
            errors++;
            $display("FAIL prescan_pos got=%0d exp=2", position);
        end
        #2 rst = 1'b0;
        #1;
        checks++;
        if (leds !== 8'h00) begin
            errors++;
            $display("FAIL midreset_leds got=%0h exp=0", leds);
        end
        checks++;
        if (position !== 3'd0) begin
            errors++;
            $display("FAIL midreset_pos got=%0d exp=0", position);
        end
        checks++;
        if (step_tick !== 1'b0) begin
            errors++;
            $display("FAIL midreset_tick got=%0b exp=0", step_tick);
        end
        @(negedge clk);
        rst = 1'b1;
    endtask

    task automatic test_bounce();
        int e;
        int cnt;
        int other;
        do_reset();
        for (int k = 1; k <= 7; k++) exp_q.push_back(k);
        for (int k = 6; k >= 0; k--) exp_q.push_back(k);
        exp_q.push_back(1);
        while (exp_q.size() > 0) begin
            wait_tick();
            @(negedge clk);
            e = exp_q.pop_front();
            checks++;
            if (position !== 3'(e)) begin
                errors++;
                $display("FAIL bounce_pos got=%0d exp=%0d", position, e);
            end
        end
        mode = 2'd3;
        exp_q.push_back(56);
        wait_tick();
        repeat (2) @(negedge clk);
        cnt = 0;
        other = 0;
        repeat (64) begin
            @(negedge clk);
            if (leds[position]) cnt++;
            if ((leds & ~(8'h01 << position)) != 8'h00) other++;
        end
        e = exp_q.pop_front();
        checks++;
        if (cnt !== e) begin
            errors++;
            $display("FAIL head_duty got=%0d exp=%0d of 64", cnt, e);
        end
        checks++;
        if (other !== 0) begin
            errors++;
            $display("FAIL head_only got=%0d exp=0 stray cycles", other);
        end
        checks++;
        if (position !== 3'd1) begin
            errors++;
            $display("FAIL hold_pos got=%0d exp=1", position);
        end
    endtask

    task automatic test_rate();
        int n;
        int e;
        do_reset();
        exp_q.push_back(4);
        count_period(n);
        e = exp_q.pop_front();
        checks++;
        if (n !== e) begin
            errors++;
            $display("FAIL rate0_period got=%0d exp=%0d", n, e);
        end
        press(1'b1, 1'b0);
        press(1'b1, 1'b0);
        exp_q.push_back(16);
        count_period(n);
        e = exp_q.pop_front();
        checks++;
        if (n !== e) begin
            errors++;
            $display("FAIL rate2_period got=%0d exp=%0d", n, e);
        end
        press(1'b1, 1'b0);
        press(1'b1, 1'b0);
        exp_q.push_back(4);
        count_period(n);
        e = exp_q.pop_front();
        checks++;
        if (n !== e) begin
            errors++;
            $display("FAIL rate_wrap_period got=%0d exp=%0d", n, e);
        end
    endtask

    task automatic test_brightness();
        int nz;
        int changes;
        int on;
        int e;
        logic [2:0] p;
        do_reset();
        repeat (7) press(1'b0, 1'b1);
        exp_q.push_back(0);
        exp_q.push_back(8);
        nz = 0;
        changes = 0;
        p = position;
        repeat (32) begin
            @(negedge clk);
            if (leds !== 8'h00) nz++;
            if (position !== p) changes++;
            p = position;
        end
        e = exp_q.pop_front();
        checks++;
        if (nz !== e) begin
            errors++;
            $display("FAIL level0_dark got=%0d exp=%0d lit cycles", nz, e);
        end
        e = exp_q.pop_front();
        checks++;
        if (changes !== e) begin
            errors++;
            $display("FAIL level0_steps got=%0d exp=%0d", changes, e);
        end
        press(1'b0, 1'b1);
        exp_q.push_back(56);
        on = 0;
        repeat (64) begin
            @(negedge clk);
            if (leds != 8'h00) on++;
        end
        e = exp_q.pop_front();
        checks++;
        if (on !== e) begin
            errors++;
            $display("FAIL level_wrap7 got=%0d exp=%0d of 64", on, e);
        end
    endtask

    task automatic test_wrap_fill();
        int n;
        int e;
        int w;
        logic [7:0] acc;
        do_reset();
        n = 0;
        do begin
            wait_tick();
            @(negedge clk);
            n++;
        end while (position !== 3'd7 && n < 20);
        mode = 2'd1;
        wait_tick();
        @(negedge clk);
        checks++;
        if (position !== 3'd0) begin
            errors++;
            $display("FAIL wrap_pos got=%0d exp=0", position);
        end
        mode = 2'd2;
        exp_q.push_back(8'h01);
        exp_q.push_back(8'h03);
        exp_q.push_back(8'h07);
        exp_q.push_back(8'h0F);
        exp_q.push_back(8'h1F);
        exp_q.push_back(8'h3F);
        exp_q.push_back(8'h7F);
        exp_q.push_back(8'hFF);
        exp_q.push_back(8'h00);
        exp_q.push_back(8'h01);
        w = 0;
        while (exp_q.size() > 0) begin
            acc = 8'h00;
            repeat (4) begin
                @(negedge clk);
                acc = acc | leds;
            end
`ifdef LED_TRAIL_EN
            // last wrap step still shows the trail on led7
            if (w == 0) acc = acc & 8'h7F;
`endif
            e = exp_q.pop_front();
            checks++;
            if (acc !== 8'(e)) begin
                errors++;
                $display("FAIL fill_step%0d got=%0h exp=%0h", w, acc, e);
            end
            w++;
        end
    endtask

    task automatic test_trail();
        int n;
        int head;
        int trail;
        int other;
        int e;
        do_reset();
        repeat (3) press(1'b1, 1'b0);
        n = 0;
        do begin
            wait_tick();
            @(negedge clk);
            n++;
        end while (position !== 3'd3 && n < 20);
        exp_q.push_back(21);
`ifdef LED_TRAIL_EN
        exp_q.push_back(9);
`else
        exp_q.push_back(0);
`endif
        head = 0;
        trail = 0;
        other = 0;
        repeat (24) begin
            @(negedge clk);
            if (leds[3]) head++;
            if (leds[2]) trail++;
            if ((leds & 8'hF3) != 8'h00) other++;
        end
        e = exp_q.pop_front();
        checks++;
        if (head !== e) begin
            errors++;
            $display("FAIL trail_head got=%0d exp=%0d of 24", head, e);
        end
        e = exp_q.pop_front();
        checks++;
        if (trail !== e) begin
            errors++;
            $display("FAIL trail_prev got=%0d exp=%0d of 24", trail, e);
        end
        checks++;
        if (other !== 0) begin
            errors++;
            $display("FAIL trail_stray got=%0d exp=0", other);
        end
    endtask

    task automatic test_back_to_back();
        int n;
        int on;
        int e;
        do_reset();
        press(1'b1, 1'b1);
        exp_q.push_back(8);
        exp_q.push_back(48);
        count_period(n);
        e = exp_q.pop_front();
        checks++;
        if (n !== e) begin
            errors++;
            $display("FAIL both_rate got=%0d exp=%0d", n, e);
        end
        on = 0;
        repeat (64) begin
            @(negedge clk);
            if (leds != 8'h00) on++;
        end
        e = exp_q.pop_front();
        checks++;
        if (on !== e) begin
            errors++;
            $display("FAIL both_level got=%0d exp=%0d of 64", on, e);
        end
    endtask

    initial begin
        test_reset();
        test_bounce();
        test_rate();
        test_brightness();
        test_wrap_fill();
        test_trail();
        test_back_to_back();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
